mem_bus_adapter: RTL
====================

// Module: mem_bus_adapter
// PURPOSE
//  Data/instruction memory port of the multicycle core, directly downstream of the control FSM.
//  Takes one core access per strobe and runs it on a valid/ready bus:
//   read addr/size, or write addr/data/size.
//  Generates byte strobes and lane alignment, waits for bus completion, and reports done or a sticky error.
//  The error is the core's error_i source.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles in REQ+WAIT_R before timeout error; 0 disables timeout
// PORTS
//  clk_i          in   1   clock
//  reset_i        in   1   synchronous, active-high reset
//  req_i          in   1   one-cycle access strobe; sampled only in IDLE
//  rd_addr_i      in   32  read byte address
//  rd_size_i      in   2   mem_access_size_t (BYTE/HALF/WORD)
//  wr_enable_i    in   1   1 = access is a write (write wins over read)
//  wr_addr_i      in   32  write byte address
//  wr_data_i      in   32  write data, right-aligned
//  wr_size_i      in   2   mem_access_size_t
//  rd_data_o      out  32  read data, right-aligned, zero-extended to size
//  done_o         out  1   one-cycle completion pulse
//  busy_o         out  1   access in flight (REQ or WAIT_R)
//  error_o        out  1   sticky error, cleared only by reset
//  error_cause_o  out  2   mem_error_t: NONE/MISALIGNED/BUS/TIMEOUT
//  bus_valid_o    out  1   request valid; held until bus_ready_i
//  bus_ready_i    in   1   request accepted when valid & ready
//  bus_addr_o     out  32  word address ({addr[31:2],2'b00})
//  bus_we_o       out  1   1 = write request
//  bus_wstrb_o    out  4   byte strobes (0 for reads)
//  bus_wdata_o    out  32  lane-replicated write data
//  bus_rvalid_i   in   1   read data valid
//  bus_rdata_i    in   32  read word
//  bus_err_i      in   1   bus error; qualified with handshake or rvalid
// BEHAVIOUR
//  Reset values
//   - All outputs 0; error_cause_o=NONE; rd_data_o=0; FSM->IDLE; timeout count 0.
//   - Reset mid-access: bus_valid_o low the next cycle.
//   - A late rvalid after reset is ignored.
//  FSM states
//   IDLE
//    - req_i & aligned -> register addr/size/data/we -> REQ.
//    - req_i & misaligned -> ERROR (MISALIGNED); no bus transaction is issued.
//    - Misaligned = HALF with addr[0]=1, or WORD with addr[1:0]!=0.
//   REQ
//    - bus_valid_o=1; all bus_* outputs stable until the handshake.
//    - On handshake with bus_err_i -> ERROR (BUS).
//    - Write handshake -> IDLE with done_o=1 the next cycle (posted write).
//    - Read handshake -> WAIT_R.
//   WAIT_R
//    - bus_rvalid_i & bus_err_i -> ERROR (BUS).
//    - bus_rvalid_i -> rd_data_o updated and done_o=1 the next cycle -> IDLE.
//    - rvalid is only honoured from the cycle after the handshake.
//   ERROR
//    - error_o=1; error_cause_o holds the first cause; busy_o=0.
//    - req_i ignored; exit only via reset.
//  Latency and strobes
//   - Earliest case: req at cycle 0, valid at 1, ready at 1.
//   - Earliest write done_o = cycle 2; earliest read (rvalid at 2) done_o = cycle 3.
//   - req_i while busy_o is ignored (no queueing).
//   - done_o is never asserted together with an error transition.
//  Timeout
//   - Counter cleared on entering REQ; increments each cycle in REQ/WAIT_R.
//   - count==TIMEOUT_CYCLES-1 without completion -> ERROR (TIMEOUT).
//  Lanes (o = addr[1:0])
//   - BYTE: wstrb=4'b0001<<o; wdata={4{d[7:0]}}; rd=zext(rdata>>(8*o))[7:0].
//   - HALF: wstrb=4'b0011<<o; wdata={2{d[15:0]}}; rd=zext(rdata>>(8*o))[15:0].
//   - WORD: wstrb=4'b1111; wdata=d; rd=rdata.
//   - Sign extension is not done here; it belongs to the regfile input mux.
//   - rd_data_o holds its value between reads; writes never change it.
// STRUCTURE
//  - Shared package additions: mem_error_t enum (NONE=0, MISALIGNED=1, BUS=2, TIMEOUT=3).
//  - mem_access_size_t is reused as-is; the FSM state enum stays local.
//  - Sub-module mem_lane_align (combinational): size + offset + data -> wstrb, wdata, extracted rdata, misaligned flag.
// TESTING
//  1 Write SW addr 0x100, data 0xDEADBEEF, ready at once
//    -> wstrb 1111, bus_addr 0x100, done_o at cycle 2.
//  2 Write SB addr 0x103, data 0x000000A5
//    -> wstrb 1000, wdata 0xA5A5A5A5, bus_addr 0x100.
//  3 Read LH addr 0x202, rdata 0x8001_1234, rvalid 3 cycles after handshake
//    -> rd_data_o 0x00008001, one done_o pulse.
//  4 Read LW addr 0x302
//    -> no bus_valid_o; error_o=1, cause MISALIGNED; later req_i ignored.
//  5 TIMEOUT_CYCLES=8, bus_ready_i held 0
//    -> ERROR (TIMEOUT) after 8 REQ cycles; bus_valid_o drops.
//  6 reset_i pulsed in WAIT_R, then rvalid arrives
//    -> outputs 0, no done_o; a fresh LB then completes normally.

Source files
------------

// File: rtl/mem_bus_adapter_pkg.sv
// Shared types for the core's memory port.
//   mem_access_size_t : access width requested by the core (BYTE/HALF/WORD)
//   mem_error_t       : sticky error cause reported to the core
package mem_bus_adapter_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_access_size_t;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_MISALIGNED = 2'd1,
    ERR_BUS        = 2'd2,
    ERR_TIMEOUT    = 2'd3
  } mem_error_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a 32-bit word bus (purely combinational).
//   i_size        access size
//   i_offset      byte offset within the word (addr[1:0])
//   i_wdata       right-aligned write data from the core
//   i_rdata       raw read word from the bus
//   o_wstrb       byte strobes for a write of this size/offset
//   o_wdata       write data replicated across every lane
//   o_rdata       read data shifted down and zero-extended to size
//   o_misaligned  size/offset combination is not naturally aligned
module mem_lane_align
  import mem_bus_adapter_pkg::*;
(
  input  mem_access_size_t i_size,
  input  logic [1:0]       i_offset,
  input  logic [31:0]      i_wdata,
  input  logic [31:0]      i_rdata,
  output logic [3:0]       o_wstrb,
  output logic [31:0]      o_wdata,
  output logic [31:0]      o_rdata,
  output logic             o_misaligned
);

  logic [31:0] w_shift;

  assign w_shift = i_rdata >> {i_offset, 3'b000};

  // Unused size encoding is treated as a word access.
  always_comb begin
    o_wstrb      = 4'b1111;
    o_wdata      = i_wdata;
    o_rdata      = i_rdata;
    o_misaligned = (i_offset != 2'b00);
    case (i_size)
      SIZE_BYTE: begin
        o_wstrb      = 4'b0001 << i_offset;
        o_wdata      = {4{i_wdata[7:0]}};
        o_rdata      = w_shift & 32'h0000_00FF;
        o_misaligned = 1'b0;
      end
      SIZE_HALF: begin
        o_wstrb      = 4'b0011 << i_offset;
        o_wdata      = {2{i_wdata[15:0]}};
        o_rdata      = w_shift & 32'h0000_FFFF;
        o_misaligned = i_offset[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_bus_adapter.sv
// Memory port of the multicycle core: runs one core access per req_i strobe
// on a valid/ready bus, then reports done_o or a sticky error.
//   clk_i, reset_i                 clock, synchronous active-high reset
//   req_i, rd_*/wr_*               core access request (write wins over read)
//   rd_data_o, done_o, busy_o      read result, completion pulse, in-flight flag
//   error_o, error_cause_o         sticky error and its first cause
//   bus_valid_o ... bus_wdata_o    request channel (held until bus_ready_i)
//   bus_rvalid_i, bus_rdata_i      read response
//   bus_err_i                      error, qualified by handshake or rvalid
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for req_i; misaligned request goes straight to ERROR
// REQ    | bus_valid_o high, request held until bus_ready_i
// WAIT_R | read accepted, waiting for bus_rvalid_i
// ERROR  | sticky error, leaves only on reset
module mem_bus_adapter
  import mem_bus_adapter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic [31:0] rd_addr_i,
  input  logic [1:0]  rd_size_i,
  input  logic        wr_enable_i,
  input  logic [31:0] wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic [1:0]  wr_size_i,
  output logic [31:0] rd_data_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        error_o,
  output logic [1:0]  error_cause_o,
  output logic        bus_valid_o,
  input  logic        bus_ready_i,
  output logic [31:0] bus_addr_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_wstrb_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT_R = 2'd2,
    S_ERROR  = 2'd3
  } state_t;

  // Down-counter loaded with TIMEOUT_CYCLES-1 when the access starts; reaching
  // zero while still waiting means the budget of REQ+WAIT_R cycles is spent.
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LOAD =
    (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_addr;
  logic             r_we;
  logic [3:0]       r_wstrb;
  logic [31:0]      r_wdata;
  mem_access_size_t r_size;
  logic [1:0]       r_off;
  logic [31:0]      r_rd_data;
  logic             r_done;
  mem_error_t       r_cause;
  logic [TW-1:0]    r_tmo_cnt;

  logic [31:0]      w_req_addr;
  mem_access_size_t w_req_size;
  mem_access_size_t w_al_size;
  logic [1:0]       w_al_off;
  logic [3:0]       w_wstrb;
  logic [31:0]      w_wdata;
  logic [31:0]      w_rdata;
  logic             w_misaligned;
  logic             w_tmo;
  logic             w_accept;
  logic             w_done_set;
  logic             w_rd_load;
  logic             w_err_set;
  mem_error_t       w_err_cause;

  assign w_req_addr = wr_enable_i ? wr_addr_i : rd_addr_i;
  assign w_req_size = mem_access_size_t'(wr_enable_i ? wr_size_i : rd_size_i);

  // One aligner serves both phases: in IDLE it sees the incoming request
  // (alignment check, write lanes to capture); afterwards it sees the captured
  // access so the returning read word is extracted with the right size/offset.
  assign w_al_size = (r_state == S_IDLE) ? w_req_size : r_size;
  assign w_al_off  = (r_state == S_IDLE) ? w_req_addr[1:0] : r_off;

  mem_lane_align u_lane_align (
    .i_size       (w_al_size),
    .i_offset     (w_al_off),
    .i_wdata      (wr_data_i),
    .i_rdata      (bus_rdata_i),
    .o_wstrb      (w_wstrb),
    .o_wdata      (w_wdata),
    .o_rdata      (w_rdata),
    .o_misaligned (w_misaligned)
  );

  assign w_tmo = (TIMEOUT_CYCLES != 0) && (r_tmo_cnt == '0);

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_done_set  = 1'b0;
    w_rd_load   = 1'b0;
    w_err_set   = 1'b0;
    w_err_cause = ERR_NONE;
    case (r_state)
      S_IDLE: begin
        if (req_i) begin
          if (w_misaligned) begin
            w_next      = S_ERROR;
            w_err_set   = 1'b1;
            w_err_cause = ERR_MISALIGNED;
          end else begin
            w_next   = S_REQ;
            w_accept = 1'b1;
          end
        end
      end
      S_REQ: begin
        // A handshake in the final budget cycle still counts as completion.
        if (bus_ready_i) begin
          if (bus_err_i) begin
            w_next      = S_ERROR;
            w_err_set   = 1'b1;
            w_err_cause = ERR_BUS;
          end else if (r_we) begin
            w_next     = S_IDLE;
            w_done_set = 1'b1;
          end else begin
            w_next = S_WAIT_R;
          end
        end else if (w_tmo) begin
          w_next      = S_ERROR;
          w_err_set   = 1'b1;
          w_err_cause = ERR_TIMEOUT;
        end
      end
      S_WAIT_R: begin
        if (bus_rvalid_i) begin
          if (bus_err_i) begin
            w_next      = S_ERROR;
            w_err_set   = 1'b1;
            w_err_cause = ERR_BUS;
          end else begin
            w_next     = S_IDLE;
            w_done_set = 1'b1;
            w_rd_load  = 1'b1;
          end
        end else if (w_tmo) begin
          w_next      = S_ERROR;
          w_err_set   = 1'b1;
          w_err_cause = ERR_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_wstrb   <= '0;
      r_wdata   <= '0;
      r_size    <= SIZE_BYTE;
      r_off     <= '0;
      r_rd_data <= '0;
      r_done    <= 1'b0;
      r_cause   <= ERR_NONE;
      r_tmo_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done_set;
      if (w_accept) begin
        r_addr    <= {w_req_addr[31:2], 2'b00};
        r_we      <= wr_enable_i;
        r_wstrb   <= wr_enable_i ? w_wstrb : 4'b0000;
        r_wdata   <= wr_enable_i ? w_wdata : 32'd0;
        r_size    <= w_req_size;
        r_off     <= w_req_addr[1:0];
        r_tmo_cnt <= TMO_LOAD;
      end else if ((r_state == S_REQ || r_state == S_WAIT_R) && (r_tmo_cnt != '0)) begin
        r_tmo_cnt <= r_tmo_cnt - 1'b1;
      end
      if (w_rd_load) begin
        r_rd_data <= w_rdata;
      end
      // ERROR is terminal, so the first cause is the only one ever written.
      if (w_err_set) begin
        r_cause <= w_err_cause;
      end
    end
  end

  assign rd_data_o     = r_rd_data;
  assign done_o        = r_done;
  assign busy_o        = (r_state == S_REQ) || (r_state == S_WAIT_R);
  assign error_o       = (r_state == S_ERROR);
  assign error_cause_o = r_cause;
  assign bus_valid_o   = (r_state == S_REQ);
  assign bus_addr_o    = r_addr;
  assign bus_we_o      = r_we;
  assign bus_wstrb_o   = r_wstrb;
  assign bus_wdata_o   = r_wdata;

endmodule
